// File: rtl/centroid_accum_bank.sv
// K-means per-centroid accumulator bank: sums classified points per centroid,
// counts members, then streams every entry to the divider and clears itself.

module accumulator_adder #(
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22,
  parameter int coord_num        = 7
) (
  input  logic [coord_num*cordinate_width-1:0]  point,
  input  logic [coord_num*accum_cord_width-1:0] accum_in,
  output logic [coord_num*accum_cord_width-1:0] accum_out
);

  // Independent per-coordinate lanes; wraparound is intended, no carry between lanes.
  for (genvar k = 0; k < coord_num; k++) begin : g_coord
    logic signed [cordinate_width-1:0]  c;
    logic signed [accum_cord_width-1:0] a;
    assign c = point[k*cordinate_width +: cordinate_width];
    assign a = accum_in[k*accum_cord_width +: accum_cord_width];
    assign accum_out[k*accum_cord_width +: accum_cord_width] = a + accum_cord_width'(c);
  end

endmodule

module centroid_accum_bank #(
  parameter int dataWidth        = 91,
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22,
  parameter int accum_width      = 154,
  parameter int centroid_num     = 8,
  parameter int count_width      = 10,
  parameter int idx_width        = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  input  logic [dataWidth-1:0]   pt_data,
  input  logic [idx_width-1:0]   pt_cent_idx,
  input  logic                   dump_req,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [idx_width-1:0]   dump_idx,
  output logic [accum_width-1:0] dump_accum,
  output logic [count_width-1:0] dump_count,
  output logic                   dump_done,
  output logic                   cnt_sat,
  output logic                   idx_err
);

  localparam logic [0:0] S_ACC  = 1'b0;
  localparam logic [0:0] S_DUMP = 1'b1;
  localparam logic [count_width-1:0] CNT_MAX = '1;

  function automatic logic [count_width-1:0] sat_inc(input logic [count_width-1:0] c);
    return (c == CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  function automatic logic in_range(input int i);
    return i < centroid_num;
  endfunction

  logic [0:0]             state;
  logic [accum_width-1:0] accum [centroid_num];
  logic [count_width-1:0] count [centroid_num];
  logic [accum_width-1:0] add_sum;
  logic                   pt_fire;
  logic                   idx_ok;
  logic                   dump_fire;
  logic                   last_entry;

  accumulator_adder #(
    .cordinate_width  (cordinate_width),
    .accum_cord_width (accum_cord_width),
    .coord_num        (7)
  ) u_adder (
    .point     (pt_data),
    .accum_in  (accum[pt_cent_idx]),
    .accum_out (add_sum)
  );

  assign pt_ready   = (state == S_ACC);
  assign dump_valid = (state == S_DUMP);
  assign pt_fire    = pt_valid & pt_ready;
  assign idx_ok     = in_range(int'(pt_cent_idx));
  assign dump_fire  = dump_valid & dump_ready;
  assign last_entry = (int'(dump_idx) == centroid_num - 1);

  // Readout is combinational from the bank; zero outside DUMP.
  assign dump_accum = dump_valid ? accum[dump_idx] : '0;
  assign dump_count = dump_valid ? count[dump_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      dump_idx  <= '0;
      dump_done <= 1'b0;
      cnt_sat   <= 1'b0;
      idx_err   <= 1'b0;
      for (int i = 0; i < centroid_num; i++) begin
        accum[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      dump_done <= 1'b0;
      case (state)
        S_ACC: begin
          if (pt_fire) begin
            if (idx_ok) begin
              accum[pt_cent_idx] <= add_sum;
              count[pt_cent_idx] <= sat_inc(count[pt_cent_idx]);
              if (count[pt_cent_idx] == CNT_MAX) cnt_sat <= 1'b1;
            end else begin
              idx_err <= 1'b1;
            end
          end
          if (dump_req) begin
            state    <= S_DUMP;
            dump_idx <= '0;
          end
        end
        S_DUMP: begin
          if (dump_fire) begin
            if (last_entry) begin
              state     <= S_ACC;
              dump_idx  <= '0;
              dump_done <= 1'b1;
              cnt_sat   <= 1'b0;
              idx_err   <= 1'b0;
              for (int i = 0; i < centroid_num; i++) begin
                accum[i] <= '0;
                count[i] <= '0;
              end
            end else begin
              dump_idx <= dump_idx + 1'b1;
            end
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_accum_bank.sv
// Bench for centroid_accum_bank: vector table, directed corner sequences and
// randomized traffic checked against a per-centroid arithmetic model.

module tb_centroid_accum_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         pt_valid;
  logic         pt_ready;
  logic [90:0]  pt_data;
  logic [2:0]   pt_cent_idx;
  logic         dump_req;
  logic         dump_valid;
  logic         dump_ready;
  logic [2:0]   dump_idx;
  logic [153:0] dump_accum;
  logic [9:0]   dump_count;
  logic         dump_done;
  logic         cnt_sat;
  logic         idx_err;

  always #5 clk = ~clk;

  centroid_accum_bank dut (
    .clk         (clk),
    .rst         (rst),
    .pt_valid    (pt_valid),
    .pt_ready    (pt_ready),
    .pt_data     (pt_data),
    .pt_cent_idx (pt_cent_idx),
    .dump_req    (dump_req),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_idx    (dump_idx),
    .dump_accum  (dump_accum),
    .dump_count  (dump_count),
    .dump_done   (dump_done),
    .cnt_sat     (cnt_sat),
    .idx_err     (idx_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer sums per centroid and coordinate, mod 2^22.
  int m_sum [8][7];
  int m_cnt [8];
  bit m_sat;

  logic [153:0] cap_acc [8];
  int           cap_cnt [8];

  typedef struct {
    logic [90:0]  pt;
    int           idx;
    bit           chk;
    logic [153:0] eacc;
    int           ecnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [90:0] pk13(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6);
    int a [7];
    logic [90:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6};
    for (int k = 0; k < 7; k++) r[k*13 +: 13] = a[k][12:0];
    return r;
  endfunction

  function automatic logic [153:0] pk22(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6);
    int a [7];
    logic [153:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6};
    for (int k = 0; k < 7; k++) r[k*22 +: 22] = a[k][21:0];
    return r;
  endfunction

  function automatic logic [153:0] model_acc(input int e);
    logic [153:0] r;
    for (int k = 0; k < 7; k++) r[k*22 +: 22] = m_sum[e][k][21:0];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      for (int k = 0; k < 7; k++) m_sum[i][k] = 0;
    end
    m_sat = 0;
  endtask

  task automatic model_add(input logic [90:0] pt, input int idx);
    for (int k = 0; k < 7; k++)
      m_sum[idx][k] = (m_sum[idx][k] + int'($signed(pt[k*13 +: 13]))) & 32'h003F_FFFF;
    if (m_cnt[idx] == 1023) m_sat = 1;
    else m_cnt[idx]++;
  endtask

  task automatic accept_cycle(input logic [90:0] pt, input int idx);
    @(negedge clk);
    pt_valid    = 1'b1;
    pt_data     = pt;
    pt_cent_idx = idx[2:0];
    chk("pt_ready_acc", pt_ready, 1);
    @(posedge clk);
    model_add(pt, idx);
  endtask

  task automatic idle();
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic do_dump(input bit with_pt, input logic [90:0] pt, input int pidx, input bit rand_stall);
    int e;
    int budget;
    @(negedge clk);
    chk("cnt_sat_pre", cnt_sat, m_sat);
    chk("dump_valid_acc", dump_valid, 0);
    dump_req    = 1'b1;
    pt_valid    = with_pt;
    pt_data     = pt;
    pt_cent_idx = pidx[2:0];
    @(posedge clk);
    if (with_pt) model_add(pt, pidx);
    @(negedge clk);
    dump_req = 1'b0;
    pt_valid = 1'b0;
    e = 0;
    budget = 0;
    while (e < 8 && budget < 400) begin
      dump_ready = rand_stall ? 1'($urandom % 2) : 1'b1;
      chk("pt_ready_dump", pt_ready, 0);
      chk("dump_valid", dump_valid, 1);
      chk("dump_idx", dump_idx, e);
      chk("dump_accum", dump_accum, model_acc(e));
      chk("dump_count", dump_count, m_cnt[e]);
      chk("dump_done_mid", dump_done, 0);
      if (dump_ready) begin
        cap_acc[e] = dump_accum;
        cap_cnt[e] = int'(dump_count);
      end
      @(posedge clk);
      if (dump_ready) e++;
      budget++;
      @(negedge clk);
    end
    if (e < 8) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: reached entry %0d expected 8", e);
    end
    dump_ready = 1'b0;
    chk("dump_done_pulse", dump_done, 1);
    chk("dump_valid_after", dump_valid, 0);
    chk("pt_ready_after", pt_ready, 1);
    chk("dump_idx_after", dump_idx, 0);
    chk("cnt_sat_after", cnt_sat, 0);
    chk("idx_err_after", idx_err, 0);
    model_clear();
    @(negedge clk);
    chk("dump_done_single", dump_done, 0);
  endtask

  initial begin
    rst = 1'b1; pt_valid = 1'b0; pt_data = '0; pt_cent_idx = '0;
    dump_req = 1'b0; dump_ready = 1'b0;
    model_clear();

    vecs[0] = '{pk13(1, 2, 3, 4, 5, 6, 7), 0, 1'b0, '0, 0};
    vecs[1] = '{pk13(-1, -2, -3, -4, -5, -6, -7), 0, 1'b1, pk22(0, 0, 0, 0, 0, 0, 0), 2};
    for (int i = 2; i < 7; i++)
      vecs[i] = '{pk13(0, -4096, 0, 0, 0, 0, 0), 3, 1'b0, '0, 0};
    vecs[6].chk  = 1'b1;
    vecs[6].eacc = pk22(0, 32'h003F_B000, 0, 0, 0, 0, 0);
    vecs[6].ecnt = 5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pt_ready", pt_ready, 1);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_idx", dump_idx, 0);
    chk("rst_dump_accum", dump_accum, 0);
    chk("rst_dump_count", dump_count, 0);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_cnt_sat", cnt_sat, 0);
    chk("rst_idx_err", idx_err, 0);

    // Table vectors, applied back to back, then checked via the readout.
    for (int i = 0; i < 7; i++) accept_cycle(vecs[i].pt, vecs[i].idx);
    idle();
    do_dump(1'b0, '0, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].chk) begin
        chk($sformatf("vec%0d_acc", i), cap_acc[vecs[i].idx], vecs[i].eacc);
        chk($sformatf("vec%0d_cnt", i), cap_cnt[vecs[i].idx], vecs[i].ecnt);
      end
    end
    for (int e = 1; e < 8; e++)
      if (e != 3) chk("vec_other_cnt", cap_cnt[e], 0);

    // Counter saturation on entry 1.
    for (int i = 0; i < 1025; i++) accept_cycle(pk13(0, 4095, 0, 0, 0, 0, 0), 1);
    idle();
    @(negedge clk);
    chk("sat_flag", cnt_sat, 1);
    do_dump(1'b0, '0, 0, 1'b0);
    chk("sat_cnt", cap_cnt[1], 1023);
    chk("sat_acc", cap_acc[1], pk22(0, 3071, 0, 0, 0, 0, 0));

    // Point arriving with dump_req is included.
    do_dump(1'b1, pk13(10, 10, 10, 10, 10, 10, 10), 5, 1'b0);
    chk("same_cycle_cnt", cap_cnt[5], 1);
    chk("same_cycle_acc", cap_acc[5], pk22(10, 10, 10, 10, 10, 10, 10));

    // Randomized traffic with gaps, stalled readout, then a fresh all-zero dump.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 200; i++) begin
        if ($urandom % 4 != 0) begin
          accept_cycle(pk13(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                            int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                            int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
                            int'($urandom_range(0, 8191)) - 4096), int'($urandom_range(0, 7)));
        end else begin
          idle();
        end
      end
      idle();
      do_dump(1'b0, '0, 0, 1'b1);
      do_dump(1'b0, '0, 0, 1'b1);
    end

    // Reset in the middle of a readout.
    for (int i = 0; i < 8; i++) accept_cycle(pk13(i + 1, 0, 0, 0, 0, 0, -1), i);
    idle();
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    dump_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_dump_idx", dump_idx, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dump_ready = 1'b0;
    model_clear();
    chk("mid_rst_pt_ready", pt_ready, 1);
    chk("mid_rst_dump_valid", dump_valid, 0);
    chk("mid_rst_dump_idx", dump_idx, 0);
    chk("mid_rst_accum", dump_accum, 0);
    chk("mid_rst_count", dump_count, 0);
    chk("mid_rst_done", dump_done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", dump_done, 0);
    end
    do_dump(1'b0, '0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/centroid_accum_bank.md
Name: centroid_accum_bank

Overview:
- Per-centroid accumulation stage of the K-means update path.
- Receives a classified point (7 coordinates) plus its winning centroid index from the assignment stage.
- Adds the point into that centroid's 7x22-bit running sum through an internal accumulator_adder instance, and increments a per-centroid member count.
- On request, streams all sums/counts to the downstream centroid divider, then clears itself for the next iteration.

Parameters:
- dataWidth, 91, packed point width (7 x cordinate_width)
- cordinate_width, 13, point coordinate width, two's complement
- accum_cord_width, 22, accumulated coordinate width
- accum_width, 154, packed accumulator width (7 x accum_cord_width)
- centroid_num, 8, number of centroids / bank entries
- count_width, 10, member counter width
- idx_width, 3, centroid index width (clog2(centroid_num))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pt_valid  in  1  point + index valid
- pt_ready  out  1  bank accepts point
- pt_data  in  dataWidth  point, coord k at [(k+1)*13-1:k*13]
- pt_cent_idx  in  idx_width  target centroid
- dump_req  in  1  start readout (level, sampled in ACC only)
- dump_valid  out  1  readout entry valid
- dump_ready  in  1  downstream accepts entry
- dump_idx  out  idx_width  entry index
- dump_accum  out  accum_width  entry sum, same packing as the adder result
- dump_count  out  count_width  entry member count
- dump_done  out  1  one-cycle pulse, readout finished and bank cleared
- cnt_sat  out  1  sticky, some count saturated
- idx_err  out  1  sticky, index >= centroid_num received

Behaviour:
- Clocking/reset: one clock, clk. rst synchronous, active-high, clears every register.
- Reset values: pt_ready=1, dump_valid=0, dump_idx=0, dump_accum=0, dump_count=0, dump_done=0, cnt_sat=0, idx_err=0. All entries zero; state ACC.
- FSM states: ACC, DUMP.
- ACC:
  - pt_ready=1.
  - Accept on pt_valid & pt_ready.
  - Accept at cycle t: accum[idx] <= adder(pt_data, accum[idx]); count[idx] += 1. Both visible at t+1.
  - Back-to-back accepts to the same index are supported every cycle (register array, no RAM read latency). 3 consecutive accepts to idx 2 give count[2]=3.
- Arithmetic:
  - Coordinates are sign-extended 13->22 and added modulo 2^22 per coordinate. No saturation, no carry between coordinates.
  - count saturates at 2^count_width-1 (1023). An accept to an entry already at 1023 still adds the point, leaves count at 1023, and sets cnt_sat.
- Out-of-range index: point accepted, no entry modified, idx_err set.
- ACC->DUMP: transition when dump_req=1 in ACC.
  - If pt_valid is also 1 that cycle, the point is accepted first (included in the dump).
  - pt_ready=0 from the next cycle.
- DUMP:
  - pt_ready=0, dump_valid=1.
  - Outputs present entry dump_idx, starting at 0, combinationally from the register array.
  - Outputs hold stable while dump_valid & !dump_ready.
  - On handshake, dump_idx increments.
  - Handshake on entry centroid_num-1 at cycle t: at t+1, state=ACC, all accum/count=0, dump_idx=0, dump_valid=0, dump_done=1 for one cycle, pt_ready=1.
  - cnt_sat and idx_err clear at the same time.
- dump_req in DUMP is ignored.
- rst mid-DUMP: immediate return to reset state; partial readout discarded; no dump_done.

Test Plan:
- Reset, then points (1,2,3,4,5,6,7)->idx0 and (-1,-2,-3,-4,-5,-6,-7)->idx0, then dump with dump_ready=1 -> entry0 accum all zeros, count=2; other entries 0/0; dump_done pulses 1 cycle after idx7 handshake.
- 5 back-to-back points coord1=-4096, others 0 ->idx3 -> dump entry3 coord1=-20480 (22-bit 0x3FB000), count=5.
- 1025 accepts of coord1=4095 ->idx1 -> count=1023, cnt_sat=1, coord1=(1025*4095) mod 2^22 = 4197375-4194304 = 3071.
- dump_req and pt_valid same cycle (idx5, all coords 10) -> point included, entry5 count=1; pt_ready=0 during DUMP.
- dump_ready toggled 1/0 randomly -> each entry held stable while stalled, emitted exactly once in order 0..7; after dump_done, a fresh dump shows all zeros.
- rst asserted during DUMP at dump_idx=4 -> next cycle pt_ready=1, all outputs reset, dump_done never pulses.
